// File: rtl/grid_pos_sched_if.sv
// Request/grant and result bundle between the playfield clients and grid_pos_sched.
// Clients drive req/idx through the master modport; the scheduler owns the slave side.
interface grid_pos_sched_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 14
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*IDX_W-1:0] idx;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   out_valid;
    logic [ID_W-1:0]        out_id;
    logic [4:0]             out_row;
    logic [4:0]             out_col;
    logic                   out_err;

    modport master (
        output req, idx,
        input  gnt, busy, out_valid, out_id, out_row, out_col, out_err
    );

    modport slave (
        input  req, idx,
        output gnt, busy, out_valid, out_id, out_row, out_col, out_err
    );
endinterface

// File: rtl/grid_pos_sched.sv
// Round-robin scheduler that converts a linear playfield index into row/column
// by repeated subtraction of COLS, returning one tagged result per grant.
module grid_pos_sched #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 14,
    parameter int COLS  = 31,
    parameter int ROWS  = 23
) (
    input logic             clk,
    input logic             rst_n,
    grid_pos_sched_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RC_W = 5;
    localparam logic [IDX_W-1:0] CELLS    = IDX_W'(ROWS * COLS);
    localparam logic [IDX_W-1:0] COLS_V   = IDX_W'(COLS);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [IDX_W-1:0]  rem_q, rem_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              out_valid_q, out_valid_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic [RC_W-1:0]   out_row_q, out_row_d;
    logic [RC_W-1:0]   out_col_q, out_col_d;
    logic              out_err_q, out_err_d;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [IDX_W-1:0]  win_idx;
    int                cand;

    // Search starts just after the previous winner so every waiter is reached within N_REQ grants.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(last_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_id    = ID_W'(cand);
            end
        end
        win_idx = bus.idx[int'(win_id)*IDX_W +: IDX_W];
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        rem_d       = rem_q;
        row_d       = row_q;
        gnt_d       = '0;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d[win_id] = 1'b1;
                    last_d        = win_id;
                    id_d          = win_id;
                    rem_d         = win_idx;
                    row_d         = '0;
                    // Out-of-range indices skip the divider and report in the grant cycle.
                    if (win_idx >= CELLS) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_row_d   = '0;
                        out_col_d   = '0;
                        out_id_d    = win_id;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (rem_q >= COLS_V) begin
                    rem_d = rem_q - COLS_V;
                    row_d = row_q + 1'b1;
                end else begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_row_d   = row_q;
                    out_col_d   = rem_q[RC_W-1:0];
                    out_err_d   = 1'b0;
                    out_id_d    = id_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            id_q        <= '0;
            rem_q       <= '0;
            row_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            rem_q       <= rem_d;
            row_q       <= row_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_err   = out_err_q;
endmodule

// File: tb/tb_grid_pos_sched.sv
// Bench for grid_pos_sched: table of single jobs with hand-computed results and latencies,
// plus arbitration and reset-abort sequences, all backed by a grant-driven scoreboard.
module tb_grid_pos_sched;
    localparam int N = 4;
    localparam int W = 14;
    localparam int C = 31;
    localparam int R = 23;

    typedef struct {
        int id;
        int row;
        int col;
        int err;
    } res_t;

    typedef struct {
        int id;
        int v;
        int row;
        int col;
        int err;
        int lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    res_t exp_q[$];
    int   grant_log[$];
    vec_t tbl[10];

    grid_pos_sched_if #(.N_REQ(N), .IDX_W(W)) bus ();

    grid_pos_sched #(.N_REQ(N), .IDX_W(W), .COLS(C), .ROWS(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic res_t model(input int id, input int v);
        res_t r;
        r.id = id;
        if (v >= R * C) begin
            r.row = 0;
            r.col = 0;
            r.err = 1;
        end else begin
            r.row = v / C;
            r.col = v % C;
            r.err = 0;
        end
        return r;
    endfunction

    // Scoreboard: expectation pushed at grant, compared at out_valid.
    int   mon_gid;
    res_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.gnt != '0) begin
                check("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
                mon_gid = oh2i(bus.gnt);
                grant_log.push_back(mon_gid);
                exp_q.push_back(model(mon_gid, int'(bus.idx[mon_gid*W +: W])));
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_result", {32'(bus.out_id), 16'(bus.out_row), 8'(bus.out_col), 8'(bus.out_err)},
                          {32'(mon_e.id), 16'(mon_e.row), 8'(mon_e.col), 8'(mon_e.err)});
                end
            end
        end
    end

    task automatic wait_gnt(output int gid);
        gid = -1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                gid = oh2i(bus.gnt);
                break;
            end
        end
        if (gid < 0) check("gnt_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus.busy && bus.req == '0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        grant_log.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_job(input vec_t t);
        int gid;
        int lat;
        int bcnt;
        res_t snap;
        bus.idx[t.id*W +: W] = W'(t.v);
        bus.req[t.id] = 1'b1;
        wait_gnt(gid);
        check("gnt_value", 64'(bus.gnt), 64'(1 << t.id));
        bus.req = '0;
        lat = -1;
        bcnt = 0;
        snap = '{-1, -1, -1, -1};
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.out_valid && lat < 0) begin
                lat = c;
                snap = '{int'(bus.out_id), int'(bus.out_row), int'(bus.out_col), int'(bus.out_err)};
            end
            if (!bus.busy) break;
        end
        check("valid_latency", 64'(lat), 64'(t.lat));
        check("busy_cycles", 64'(bcnt), 64'(t.lat + 1));
        check("result", {16'(snap.id), 16'(snap.row), 16'(snap.col), 16'(snap.err)},
              {16'(t.id), 16'(t.row), 16'(t.col), 16'(t.err)});
        check("result_hold", {16'(bus.out_id), 16'(bus.out_row), 16'(bus.out_col), 16'(bus.out_err)},
              {16'(t.id), 16'(t.row), 16'(t.col), 16'(t.err)});
    endtask

    initial begin
        int gid;
        int vcnt;
        int exp_order[5];

        errors = 0;
        checks = 0;
        tbl[0] = '{1, 0,     0,  0,  0, 1};
        tbl[1] = '{0, 712,   22, 30, 0, 23};
        tbl[2] = '{2, 45,    1,  14, 0, 2};
        tbl[3] = '{3, 30,    0,  30, 0, 1};
        tbl[4] = '{0, 31,    1,  0,  0, 2};
        tbl[5] = '{1, 713,   0,  0,  1, 0};
        tbl[6] = '{2, 16383, 0,  0,  1, 0};
        tbl[7] = '{3, 400,   12, 28, 0, 13};
        tbl[8] = '{0, 620,   20, 0,  0, 21};
        tbl[9] = '{1, 711,   22, 29, 0, 23};

        rst_n = 1'b0;
        bus.req = '0;
        bus.idx = '0;
        @(negedge clk);
        check("reset_outputs",
              {32'(bus.gnt), 8'(bus.busy), 8'(bus.out_valid), 4'(bus.out_id), 5'(bus.out_row), 5'(bus.out_col), 2'(bus.out_err)},
              64'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i]);
        end
        wait_drain();

        // All four requesting continuously: rotation 0,1,2,3 then 0 again.
        do_reset();
        bus.idx = {14'd30, 14'd93, 14'd62, 14'd31};
        bus.req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(gid);
            if (g == 4) bus.req = '0;
        end
        wait_drain();
        exp_order = '{0, 1, 2, 3, 0};
        check("rr_count", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_order[i]));
        end

        // Requester 0 always requesting, requester 2 once: 0,2,0.
        do_reset();
        bus.idx = '0;
        bus.idx[0*W +: W] = 14'd5;
        bus.idx[2*W +: W] = 14'd100;
        bus.req = 4'b0101;
        for (int g = 0; g < 3; g++) begin
            wait_gnt(gid);
            if (gid == 2) bus.req[2] = 1'b0;
            if (g == 2) bus.req = '0;
        end
        wait_drain();
        exp_order = '{0, 2, 0, 0, 0};
        check("fair_count", 64'(grant_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("fair_order", 64'((i < grant_log.size()) ? grant_log[i] : -1), 64'(exp_order[i]));
        end

        // Reset in the middle of a long division.
        bus.idx[1*W +: W] = 14'd400;
        bus.req = 4'b0010;
        wait_gnt(gid);
        check("abort_gnt", 64'(gid), 64'd1);
        bus.req = '0;
        repeat (5) @(negedge clk);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_async_clear",
              {32'(bus.gnt), 8'(bus.busy), 8'(bus.out_valid), 4'(bus.out_id), 5'(bus.out_row), 5'(bus.out_col), 2'(bus.out_err)},
              64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        check("abort_no_valid", 64'(vcnt), 64'd0);

        // Pointer is back at N_REQ-1, so requester 0 beats requester 2.
        grant_log.delete();
        bus.idx[0*W +: W] = 14'd45;
        bus.idx[2*W +: W] = 14'd45;
        bus.req = 4'b0101;
        wait_gnt(gid);
        check("post_reset_first", 64'(gid), 64'd0);
        bus.req[0] = 1'b0;
        wait_gnt(gid);
        check("post_reset_second", 64'(gid), 64'd2);
        bus.req = '0;
        wait_drain();
        check("post_reset_result", {16'(bus.out_id), 16'(bus.out_row), 16'(bus.out_col), 16'(bus.out_err)},
              {16'd2, 16'd1, 16'd14, 16'd0});
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/grid_pos_sched.md
# grid_pos_sched

Multi-requester scheduler for the playfield index-to-position service. It accepts linear cell indices from up to `N_REQ` clients (game logic, renderer, collision check) and arbitrates among them round-robin. For the granted index it computes row and column by sequential subtraction, so no `/` or `%` operators are needed. It returns one tagged result per grant, and the downstream one-hot grid decode consumes the registered `out_row`/`out_col`.

## Interface
- `N_REQ`, 4: number of requesters; 2..8.
- `IDX_W`, 14: index width.
- `COLS`, 31: cells per row; the divisor.
- `ROWS`, 23: rows in the playfield; valid indices are 0..ROWS*COLS-1 (0..712).
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request level.
- `idx`  in  N_REQ*IDX_W  requester k's index in bits [k*IDX_W +: IDX_W].
- `gnt`  out  N_REQ  one-hot, one-cycle pulse; the index was captured.
- `busy`  out  1  high whenever state != IDLE.
- `out_valid`  out  1  one-cycle result strobe.
- `out_id`  out  $clog2(N_REQ)  requester the result belongs to.
- `out_row`  out  5  quotient idx/COLS.
- `out_col`  out  5  remainder idx%COLS.
- `out_err`  out  1  index was out of range; qualified by `out_valid`.

## Operation
- Reset values:
  - state IDLE.
  - `gnt`=0, `busy`=0, `out_valid`=0, `out_id`=0, `out_row`=0, `out_col`=0, `out_err`=0.
  - Round-robin pointer `last`=N_REQ-1, so requester 0 wins the first contest.
- FSM has three states: IDLE, DIV, DONE.
- IDLE, when |req is high:
  - Pick the first asserted requester in order last+1, last+2, … (mod N_REQ).
  - Capture its idx into `rem`, set row counter 0, set `last` to the winner, register `gnt`[winner]=1 and the winner id.
  - If the captured idx >= ROWS*COLS, go to DONE with `out_err`=1, `out_row`=0, `out_col`=0.
  - Otherwise go to DIV.
- IDLE with no request: stay in IDLE; all strobes stay 0.
- DIV:
  - If rem >= COLS: rem <= rem-COLS and row <= row+1; stay in DIV.
  - Else: load `out_row`=row, `out_col`=rem[4:0], `out_err`=0, `out_id`; go to DONE.
- DONE: `out_valid`=1 for exactly this cycle, then go to IDLE unconditionally.
- `out_row`, `out_col`, `out_id` and `out_err` hold their values until the next DONE. They are not cleared when `out_valid` falls.
- Requesters hold `req` and `idx` stable until they see their `gnt`. After `gnt`, the index may change freely.
- A `req` still high when IDLE next samples is treated as a new request.
- Arithmetic: `rem` is IDX_W bits unsigned. The range check uses the constant ROWS*COLS at IDX_W width. Row never exceeds ROWS-1 on the non-error path.
- Requests that arrive while busy are not lost. They are simply not sampled until IDLE.

## Timing
- Let t0 be the edge at which IDLE samples the winning request, and q = idx/COLS.
- `gnt` is high from t0 to t0+1.
- DIV occupies edges t0+1 … t0+q+1; the last of these does the final compare and loads the result.
- `out_valid` is high from t0+q+1 to t0+q+2.
- The earliest next sample edge is t0+q+3. Service time is q+3 cycles: 3 for idx 0..30, 25 for idx 712.
- Out-of-range index: `gnt` and `out_valid` (with `out_err`=1) are high in the same cycle, t0..t0+1. The next sample is at t0+2.
- Simultaneous requests: exactly one `gnt` bit is set per contest. Starvation is impossible; any waiting requester is served within N_REQ grants.
- Reset asserted mid-DIV or mid-DONE:
  - Immediate return to reset values.
  - No `out_valid` is issued for the aborted job.
  - `last` returns to N_REQ-1.
- Reset deasserted: the first sample is at the first rising edge after release.

## Test plan
- Single request, requester 1 with idx=0, others idle:
  - `gnt`=0b0010 in cycle 1.
  - `out_valid` in cycle 2 with row=0, col=0, id=1, err=0.
- idx=712 on requester 0: `out_valid` at t0+23 with row=22, col=30, err=0; `busy` is high for 24 cycles.
- idx=713 and then idx=16383: `gnt` and `out_valid` fire together with err=1, row=0, col=0, and there is no DIV dwell.
- All four requesters held high with idx=31, 62, 93, 30:
  - Grants arrive in order 0, 1, 2, 3.
  - Results are (1,0), (2,0), (3,0), (0,30) with matching `out_id`.
  - A fifth contest, with all four still requesting, grants requester 0 again.
- Requester 0 holds `req` high continuously while requester 2 requests once: grants alternate 0, 2, 0, and requester 2 waits at most one job.
- `rst_n` pulsed low during DIV for idx=400 (q=12):
  - All outputs return to 0 asynchronously and no `out_valid` follows.
  - After release, a new idx=45 request yields row=1, col=14.
